// File: rtl/co_isa_pkg.sv
// Shared ISA definitions for the lab CPU front end.
// Holds the opcode field width, opcode encodings and the fetch FSM state
// type used by instr_fetch_unit.
package co_isa_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_RTYPE = 3'b000;
  localparam logic [OP_W-1:0] OP_ADDI  = 3'b001;
  localparam logic [OP_W-1:0] OP_SLTI  = 3'b010;
  localparam logic [OP_W-1:0] OP_LW    = 3'b011;
  localparam logic [OP_W-1:0] OP_SW    = 3'b100;
  localparam logic [OP_W-1:0] OP_BEQ   = 3'b101;
  localparam logic [OP_W-1:0] OP_BNE   = 3'b110;
  localparam logic [OP_W-1:0] OP_JMP   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO buffering fetched {pc, instr} entries.
// Ports:
//   clk_i, rst_i : clock, async active-high reset
//   push, wdata  : write one entry
//   pop          : drop the head entry
//   flush        : empty the FIFO; wins over push and pop
//   count        : number of valid entries
//   head         : entry at the read pointer
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  // Storage is cleared on reset so the head outputs read as zero after reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i)
    !(push && !flush && !pop && count_q == FULL_CNT));
  a_no_pop_empty: assert property (@(posedge clk_i) disable iff (rst_i)
    !(pop && !flush && count_q == '0));

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: issues in-order word reads to instruction
// memory (one outstanding), buffers returned words with their PC in a small
// FIFO and presents the head to decode. Redirects flush buffered and
// in-flight fetches and restart at the new PC.
// Ports:
//   clk_i, rst_i            : clock, async active-high reset
//   imem_req_o/addr_o       : read request and byte address (held until ready)
//   imem_ready_i            : memory accepts the request
//   imem_rvalid_i/rdata_i   : in-order read response
//   redirect_i/redirect_pc_i: flush and restart fetch
//   instr_valid_o/ready_i   : decode handshake on the FIFO head
//   instr_o/op_o/pc_o       : head instruction, its opcode field and PC
//
// state   | meaning
// IDLE    | no request, no response pending; waits for FIFO credit
// REQ     | request driven, waiting for imem_ready_i
// WAIT    | request accepted, waiting for imem_rvalid_i
module instr_fetch_unit
  import co_isa_pkg::*;
#(
  parameter int                INSTR_W  = 16,
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                DEPTH    = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  output logic               imem_req_o,
  output logic [ADDR_W-1:0]  imem_addr_o,
  input  logic               imem_ready_i,
  input  logic               imem_rvalid_i,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  input  logic               redirect_i,
  input  logic [ADDR_W-1:0]  redirect_pc_i,
  output logic               instr_valid_o,
  input  logic               instr_ready_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [OP_W-1:0]    instr_op_o,
  output logic [ADDR_W-1:0]  instr_pc_o
);

  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam int ENTRY_W = ADDR_W + INSTR_W;
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(INSTR_W / 8);

  fetch_state_t state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              discard_q, discard_d;
  // stale_q: the request still pending in REQ was issued before a redirect,
  // so its response must be dropped and pc_q already holds the new target.
  logic              stale_q, stale_d;

  logic              push;
  logic              pop;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W:0]    count_after;
  logic              credit;
  logic [ENTRY_W-1:0] head;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      pc_q      <= RESET_PC;
      addr_q    <= RESET_PC;
      discard_q <= 1'b0;
      stale_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      addr_q    <= addr_d;
      discard_q <= discard_d;
      stale_q   <= stale_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    addr_d      = addr_q;
    discard_d   = discard_q;
    stale_d     = stale_q;
    push        = 1'b0;
    count_after = '0;
    credit      = 1'b0;

    if (redirect_i) begin
      pc_d = redirect_pc_i;
    end

    case (state_q)
      ST_IDLE: begin
        if (!redirect_i && fifo_count < FULL_CNT) begin
          state_d = ST_REQ;
          addr_d  = pc_q;
        end
      end
      ST_REQ: begin
        if (imem_ready_i) begin
          state_d   = ST_WAIT;
          discard_d = stale_q | redirect_i;
          stale_d   = 1'b0;
          if (!redirect_i && !stale_q) begin
            pc_d = pc_q + PC_STEP;
          end
        end else if (redirect_i) begin
          stale_d = 1'b1;
        end
      end
      ST_WAIT: begin
        if (imem_rvalid_i) begin
          push      = !discard_q && !redirect_i;
          discard_d = 1'b0;
          // Credit is judged on the occupancy this cycle will leave behind.
          if (!redirect_i) begin
            count_after = {1'b0, fifo_count};
            if (push) count_after = count_after + (CNT_W+1)'(1);
            if (pop)  count_after = count_after - (CNT_W+1)'(1);
          end
          credit = count_after < {1'b0, FULL_CNT};
          if (credit) begin
            state_d = ST_REQ;
            addr_d  = pc_d;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (redirect_i) begin
          discard_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign pop = instr_valid_o & instr_ready_i;

  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (push),
    .wdata ({addr_q, imem_rdata_i}),
    .pop   (pop),
    .flush (redirect_i),
    .count (fifo_count),
    .head  (head)
  );

  assign imem_req_o    = (state_q == ST_REQ);
  assign imem_addr_o   = addr_q;
  assign instr_valid_o = (fifo_count != '0);
  assign instr_pc_o    = head[ENTRY_W-1 -: ADDR_W];
  assign instr_o       = head[INSTR_W-1:0];
  assign instr_op_o    = instr_o[INSTR_W-1 -: OP_W];

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  localparam int DEPTH = 2;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        imem_req_o;
  logic [15:0] imem_addr_o;
  logic        imem_ready_i;
  logic        imem_rvalid_i;
  logic [15:0] imem_rdata_i;
  logic        redirect_i;
  logic [15:0] redirect_pc_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [15:0] instr_o;
  logic [2:0]  instr_op_o;
  logic [15:0] instr_pc_o;

  // second instance only for the RESET_PC wrap case
  logic        req2;
  logic [15:0] addr2;
  logic        ready2;
  logic        rvalid2;
  logic [15:0] rdata2;
  logic        redir2;
  logic [15:0] rpc2;
  logic        valid2;
  logic        iready2;
  logic [15:0] instr2;
  logic [2:0]  op2;
  logic [15:0] pc2;

  always #5 clk_i = ~clk_i;

  instr_fetch_unit u_dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_ready_i  (imem_ready_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .instr_o       (instr_o),
    .instr_op_o    (instr_op_o),
    .instr_pc_o    (instr_pc_o)
  );

  instr_fetch_unit #(.RESET_PC(16'hFFFE)) u_dut2 (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .imem_req_o    (req2),
    .imem_addr_o   (addr2),
    .imem_ready_i  (ready2),
    .imem_rvalid_i (rvalid2),
    .imem_rdata_i  (rdata2),
    .redirect_i    (redir2),
    .redirect_pc_i (rpc2),
    .instr_valid_o (valid2),
    .instr_ready_i (iready2),
    .instr_o       (instr2),
    .instr_op_o    (op2),
    .instr_pc_o    (pc2)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (a == 16'h0000) return 16'h2A05;
    if (a == 16'h0002) return 16'hE010;
    return 16'(a * 16'h9E37) ^ 16'h5A3C;
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(posedge clk_i);
    #2;
  endtask

  // knobs
  int          mem_ready_pct = 100;
  int          lat_knob      = 1;   // 0 = random 1..3
  int          dec_ready_pct = 100;
  int          redir_pct     = 0;
  logic        force_redir   = 1'b0;
  logic [15:0] force_pc      = '0;
  logic        arm_rvp       = 1'b0;
  logic [15:0] rvp_pc        = '0;
  logic        rvp_fired     = 1'b0;

  // reference model: transaction-level view of the fetch stream
  typedef struct { logic [15:0] pc; logic [15:0] instr; } entry_t;
  typedef struct { logic [15:0] pc; logic [15:0] instr; logic [2:0] op; } pop_t;
  entry_t      exp_q[$];
  pop_t        pop_log[$];
  logic [15:0] acc_log[$];
  int          acc_cyc[$];
  logic [15:0] acc2[$];

  logic        exp_req;
  logic [15:0] exp_addr;
  logic [15:0] model_pc;
  logic        pend_live;
  logic        outst;
  logic        out_live;
  logic [15:0] out_addr;
  int          resp_due;
  int          cyc;

  initial begin
    logic        rv, pop, redir, accept, prev_req;
    logic [15:0] rpc;
    int          size_before;
    imem_ready_i  = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    instr_ready_i = 1'b0;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        exp_q.delete(); pop_log.delete(); acc_log.delete(); acc_cyc.delete();
        exp_req = 1'b0; exp_addr = 16'h0000; model_pc = 16'h0000;
        pend_live = 1'b0; outst = 1'b0; out_live = 1'b0; out_addr = '0;
        resp_due = 0; cyc = 0;
        imem_ready_i = 1'b0; imem_rvalid_i = 1'b0; redirect_i = 1'b0; instr_ready_i = 1'b0;
        continue;
      end
      chk("instr_valid", instr_valid_o, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        chk("instr_pc", instr_pc_o, exp_q[0].pc);
        chk("instr", instr_o, exp_q[0].instr);
        chk("instr_op", instr_op_o, exp_q[0].instr[15:13]);
      end
      chk("imem_req", imem_req_o, exp_req);
      if (exp_req) chk("imem_addr", imem_addr_o, exp_addr);

      imem_ready_i  = ($urandom_range(99) < mem_ready_pct);
      instr_ready_i = ($urandom_range(99) < dec_ready_pct);
      rv = outst && (cyc == resp_due);
      imem_rvalid_i = rv;
      imem_rdata_i  = rv ? mem_word(out_addr) : 16'($urandom);
      pop   = (exp_q.size() != 0) && instr_ready_i;
      redir = force_redir || (redir_pct > 0 && $urandom_range(99) < redir_pct);
      rpc   = force_redir ? force_pc : (16'($urandom) & 16'hFFFE);
      force_redir = 1'b0;
      if (arm_rvp && rv && pop) begin
        redir = 1'b1; rpc = rvp_pc; arm_rvp = 1'b0; rvp_fired = 1'b1;
      end
      redirect_i    = redir;
      redirect_pc_i = rpc;
      accept      = exp_req && imem_ready_i;
      size_before = exp_q.size();

      if (pop) begin
        if (!redir) pop_log.push_back('{instr_pc_o, instr_o, instr_op_o});
        void'(exp_q.pop_front());
      end
      if (rv) begin
        outst = 1'b0;
        if (out_live && !redir) exp_q.push_back('{out_addr, mem_word(out_addr)});
      end
      if (accept) begin
        acc_log.push_back(imem_addr_o);
        acc_cyc.push_back(cyc);
        outst    = 1'b1;
        out_addr = exp_addr;
        out_live = pend_live && !redir;
        resp_due = cyc + ((lat_knob == 0) ? int'($urandom_range(3, 1)) : lat_knob);
        if (pend_live && !redir) model_pc = model_pc + 16'd2;
      end
      if (redir) begin
        exp_q.delete();
        out_live = 1'b0;
        if (!accept) pend_live = 1'b0;
        model_pc = rpc;
      end

      prev_req = exp_req;
      if (exp_req && !accept)  exp_req = 1'b1;
      else if (accept)         exp_req = 1'b0;
      else if (rv)             exp_req = (exp_q.size() < DEPTH);
      else if (outst)          exp_req = 1'b0;
      else                     exp_req = (size_before < DEPTH) && !redir;
      if (exp_req && !prev_req) begin
        exp_addr  = model_pc;
        pend_live = 1'b1;
      end
      cyc++;
    end
  end

  // single-cycle memory for the wrapping instance
  initial begin
    logic        out2;
    logic [15:0] out2_addr;
    out2 = 1'b0; out2_addr = '0;
    ready2 = 1'b1; rvalid2 = 1'b0; rdata2 = '0; redir2 = 1'b0; rpc2 = '0; iready2 = 1'b1;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        acc2.delete(); out2 = 1'b0; rvalid2 = 1'b0;
        continue;
      end
      rvalid2 = out2;
      rdata2  = mem_word(out2_addr);
      out2    = 1'b0;
      if (req2) begin
        acc2.push_back(addr2);
        out2 = 1'b1;
        out2_addr = addr2;
      end
    end
  end

  task automatic do_reset();
    rst_i = 1'b1;
    cycles(2);
    rst_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1;
    cycles(2);
    chk("rst_req", imem_req_o, 1'b0);
    chk("rst_addr", imem_addr_o, 16'h0000);
    chk("rst_valid", instr_valid_o, 1'b0);
    chk("rst_instr", instr_o, 16'h0000);
    chk("rst_op", instr_op_o, 3'b000);
    chk("rst_pc", instr_pc_o, 16'h0000);
    chk("rst_addr2", addr2, 16'hFFFE);
    rst_i = 1'b0;

    // basic stream, single-cycle memory, decode always ready
    cycles(12);
    chk("p1_acc_count", acc_log.size() >= 3, 1'b1);
    chk("p1_pop_count", pop_log.size() >= 2, 1'b1);
    if (acc_log.size() >= 3) begin
      chk("p1_acc0", acc_log[0], 16'h0000);
      chk("p1_acc1", acc_log[1], 16'h0002);
      chk("p1_acc2", acc_log[2], 16'h0004);
      chk("p1_spacing", acc_cyc[1] - acc_cyc[0], 2);
    end
    if (pop_log.size() >= 2) begin
      chk("p1_pop0_pc", pop_log[0].pc, 16'h0000);
      chk("p1_pop0_op", pop_log[0].op, 3'b001);
      chk("p1_pop0_instr", pop_log[0].instr, 16'h2A05);
      chk("p1_pop1_op", pop_log[1].op, 3'b111);
      chk("p1_pop1_instr", pop_log[1].instr, 16'hE010);
    end
    chk("wrap_count", acc2.size() >= 2, 1'b1);
    if (acc2.size() >= 2) begin
      chk("wrap_acc0", acc2[0], 16'hFFFE);
      chk("wrap_acc1", acc2[1], 16'h0000);
    end

    // decode stalled: FIFO fills to DEPTH and fetch stops
    dec_ready_pct = 0;
    do_reset();
    cycles(12);
    chk("p2_acc_count", acc_log.size(), 2);
    chk("p2_req_low", imem_req_o, 1'b0);
    chk("p2_valid", instr_valid_o, 1'b1);
    dec_ready_pct = 100;
    cycles(8);
    chk("p2_pops", pop_log.size() >= 2, 1'b1);
    if (pop_log.size() >= 2) begin
      chk("p2_pop0_pc", pop_log[0].pc, 16'h0000);
      chk("p2_pop1_pc", pop_log[1].pc, 16'h0002);
    end
    chk("p2_resume", acc_log.size() >= 3, 1'b1);
    if (acc_log.size() >= 3) chk("p2_acc2", acc_log[2], 16'h0004);

    // redirect while waiting on a 3-cycle response
    lat_knob = 3;
    do_reset();
    for (int i = 0; i < 20 && acc_log.size() < 1; i++) cycles(1);
    chk("p3_first_accept", acc_log.size() >= 1, 1'b1);
    force_pc = 16'h0040; force_redir = 1'b1;
    for (int i = 0; i < 40 && pop_log.size() < 1; i++) cycles(1);
    chk("p3_pop_seen", pop_log.size() >= 1, 1'b1);
    if (pop_log.size() >= 1) begin
      chk("p3_pop0_pc", pop_log[0].pc, 16'h0040);
      chk("p3_pop0_instr", pop_log[0].instr, mem_word(16'h0040));
    end
    if (acc_log.size() >= 2) chk("p3_acc1", acc_log[1], 16'h0040);

    // redirect while the request is stalled
    lat_knob = 1; mem_ready_pct = 0;
    do_reset();
    for (int i = 0; i < 10 && imem_req_o !== 1'b1; i++) cycles(1);
    chk("p4_req_up", imem_req_o, 1'b1);
    force_pc = 16'h0080; force_redir = 1'b1;
    cycles(4);
    chk("p4_req_held", imem_req_o, 1'b1);
    chk("p4_addr_held", imem_addr_o, 16'h0000);
    mem_ready_pct = 100;
    for (int i = 0; i < 20 && acc_log.size() < 2; i++) cycles(1);
    chk("p4_acc_count", acc_log.size() >= 2, 1'b1);
    if (acc_log.size() >= 2) begin
      chk("p4_acc0", acc_log[0], 16'h0000);
      chk("p4_acc1", acc_log[1], 16'h0080);
    end
    for (int i = 0; i < 20 && pop_log.size() < 1; i++) cycles(1);
    chk("p4_pop_seen", pop_log.size() >= 1, 1'b1);
    if (pop_log.size() >= 1) chk("p4_pop0_pc", pop_log[0].pc, 16'h0080);

    // redirect, rvalid and pop in one cycle
    dec_ready_pct = 50;
    do_reset();
    rvp_fired = 1'b0; rvp_pc = 16'h00C0; arm_rvp = 1'b1;
    for (int i = 0; i < 300 && !rvp_fired; i++) cycles(1);
    chk("p5_fired", rvp_fired, 1'b1);
    if (rvp_fired) begin
      chk("p5_empty", instr_valid_o, 1'b0);
      chk("p5_req", imem_req_o, 1'b1);
      chk("p5_addr", imem_addr_o, 16'h00C0);
    end
    arm_rvp = 1'b0;

    // randomized run against the model
    mem_ready_pct = 70; lat_knob = 0; dec_ready_pct = 60; redir_pct = 4;
    do_reset();
    cycles(2500);
    chk("rand_pops", pop_log.size() > 50, 1'b1);

    // reset asserted mid-WAIT
    redir_pct = 0; lat_knob = 3; mem_ready_pct = 100; dec_ready_pct = 0;
    for (int i = 0; i < 20 && !outst; i++) cycles(1);
    chk("mid_wait", outst, 1'b1);
    rst_i = 1'b1;
    #1;
    chk("mid_rst_req", imem_req_o, 1'b0);
    chk("mid_rst_addr", imem_addr_o, 16'h0000);
    chk("mid_rst_valid", instr_valid_o, 1'b0);
    chk("mid_rst_instr", instr_o, 16'h0000);
    chk("mid_rst_op", instr_op_o, 3'b000);
    chk("mid_rst_pc", instr_pc_o, 16'h0000);
    cycles(2);
    rst_i = 1'b0;
    dec_ready_pct = 100; lat_knob = 1;
    cycles(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch front end for the lab CPU: it holds the fetch PC, issues in-order word reads to instruction memory over a request/response handshake, buffers returned instructions in a small FIFO and presents them, with their PC and 3-bit opcode field, to the decode stage. It is the producer side of the opcode interface that the control decoder consumes. Branch/jump redirects from execute flush buffered and in-flight fetches.

## Interface
- `INSTR_W`, 16: instruction width; opcode is `instr[INSTR_W-1 -: 3]`.
- `ADDR_W`, 16: byte address width.
- `RESET_PC`, 0: first fetch address after reset.
- `DEPTH`, 2: FIFO entries; power of two, at least 2.

Ports (clock and reset first):
- `clk_i` in 1: clock, rising edge.
- `rst_i` in 1: reset, asynchronous, active-high.
- `imem_req_o` out 1: read request valid.
- `imem_addr_o` out ADDR_W: request byte address.
- `imem_ready_i` in 1: memory accepts request this cycle.
- `imem_rvalid_i` in 1: read data valid; responses arrive in order, at most one outstanding.
- `imem_rdata_i` in INSTR_W: read data.
- `redirect_i` in 1: flush and restart at `redirect_pc_i`.
- `redirect_pc_i` in ADDR_W: new fetch PC.
- `instr_valid_o` out 1: FIFO head valid.
- `instr_ready_i` in 1: decode consumes head.
- `instr_o` out INSTR_W: head instruction.
- `instr_op_o` out 3: head opcode field.
- `instr_pc_o` out ADDR_W: head PC.

## Operation
- FSM `IDLE`, `REQ`, `WAIT`, plus `pc_q`, `discard_q`, FIFO with count.
- `IDLE`: go to `REQ` when `count < DEPTH` and not `redirect_i`. With one outstanding, the entry in flight is always reserved.
- `REQ`: `imem_req_o=1`, `imem_addr_o=pc_q`. Address and req stay stable until `imem_ready_i`. On accept, `pc_q <= pc_q + INSTR_W/8` (wraps mod 2^ADDR_W) and the FSM goes to `WAIT`.
- `WAIT`: on `imem_rvalid_i`:
  - If `discard_q=0`, push `{pc, rdata}`; otherwise drop the data and clear `discard_q`.
  - Next state is `REQ` if credit is available, else `IDLE`.
- `redirect_i` (any state):
  - FIFO is emptied, `pc_q <= redirect_pc_i`. Redirect beats the PC increment and the push.
  - In `WAIT` without a same-cycle rvalid, set `discard_q`.
  - In `REQ` without same-cycle accept, the request stays pending at its old address until accepted, then is discarded (`discard_q` set at acceptance). The next request uses the redirect PC.
  - In `REQ` with same-cycle accept, set `discard_q`.
  - Redirect and pop in the same cycle: the flush wins; decode treats that instruction as killed.
- Push and pop in the same cycle: count unchanged. Pop on empty and push on full cannot occur by construction; assertions check both.
- `instr_op_o` is always `instr_o[INSTR_W-1 -: 3]`.

## Timing
- Reset values:
  - `imem_req_o=0`, `imem_addr_o=RESET_PC`, `instr_valid_o=0`.
  - `instr_o`, `instr_op_o` = 0; `instr_pc_o` = 0.
  - FSM in `IDLE`, `discard_q=0`, count 0.
- First request: first rising edge after reset release moves to `REQ`; `imem_req_o` is high in the following cycle.
- Request accepted in cycle T, `rvalid` in cycle T+k: `instr_valid_o` is high from cycle T+k+1.
- Steady-state throughput is 1 instruction per 2 cycles with a single-cycle memory (request in T, rvalid in T+1, next request in T+2).
- Redirect in cycle T: `instr_valid_o=0` in T+1. The first redirect-target request is no earlier than T+1, or later if an outstanding read must drain.
- Outputs are registered or decoded from registers; there is no combinational input-to-output path except none.

## Structure
- Package `co_isa_pkg`:
  - `OP_W=3`.
  - Opcode constants `OP_RTYPE=3'b000`, `OP_ADDI=3'b001`, `OP_SLTI=3'b010`, `OP_LW=3'b011`, `OP_SW=3'b100`, `OP_BEQ=3'b101`, `OP_BNE=3'b110`, `OP_JMP=3'b111`.
  - Fetch FSM state typedef.
- Sub-module `fetch_fifo`: synchronous FIFO of `{ADDR_W+INSTR_W}` bits.
  - Ports: push, pop, flush, count, head.
  - Flush has priority over push and pop.

## Test plan
- Reset, then single-cycle memory returning `16'h2A05` at 0 and `16'hE010` at 2, decode always ready:
  - Request addresses are 0, 2, 4…
  - First output `instr_pc_o=0`, `instr_op_o=3'b001`; second output `instr_op_o=3'b111`.
- `instr_ready_i=0` for 10 cycles:
  - Exactly DEPTH=2 entries buffered, `imem_req_o` stays low.
  - Ready is then raised: pops occur in PC order 0, 2 and fetch resumes at 4.
- Redirect to `16'h0040` while in `WAIT` with 3-cycle memory latency:
  - The late response is dropped.
  - The next delivered instruction has `instr_pc_o=16'h0040`.
- Redirect while `imem_req_o=1`, `imem_ready_i=0` for 4 cycles:
  - Address stays constant until accept, and that response is discarded.
  - The next request address is the redirect PC.
- Redirect, rvalid and pop all in the same cycle:
  - FIFO empty next cycle, no push.
  - Fetch restarts at the redirect PC.
- `RESET_PC=16'hFFFE`: the second request address wraps to `16'h0000`. Asserting `rst_i` mid-`WAIT` returns all outputs to their reset values immediately.
